// File: rtl/buffer_fifo_pkg.sv
// rtl/buffer_fifo_pkg.sv - handshake event decode shared by the FWFT FIFO controller
package buffer_fifo_pkg;

    typedef struct packed {
        logic accept;
        logic issue;
        logic pop;
    } fifo_ev_t;

    // Issue refills the output register whenever RAM holds a word and the slot is free or draining.
    function automatic fifo_ev_t decode_ev(
        input logic in_valid,
        input logic in_ready,
        input logic out_valid,
        input logic out_ready,
        input logic ram_nonempty
    );
        fifo_ev_t ev;
        ev.accept = in_valid & in_ready;
        ev.issue  = ram_nonempty & (~out_valid | out_ready);
        ev.pop    = out_valid & out_ready;
        return ev;
    endfunction

endpackage

// File: rtl/buffer_fifo_buffer.sv
// rtl/buffer_fifo_buffer.sv - simple dual-port RAM macro with registered read data
module buffer #(
    parameter int addrLen = 6,
    parameter int dataLen = 32,
    parameter int memSize = 1 << addrLen
) (
    input  logic               clk,
    input  logic               wrt,
    input  logic [addrLen-1:0] wrt_addr,
    input  logic [dataLen-1:0] data_in,
    input  logic               rd_en,
    input  logic [addrLen-1:0] rd_addr,
    output logic [dataLen-1:0] data_out
);

    logic [dataLen-1:0] mem [memSize];

    always_ff @(posedge clk) begin
        if (wrt) begin
            mem[wrt_addr] <= data_in;
        end
        if (rd_en) begin
            data_out <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/buffer_fifo.sv
// rtl/buffer_fifo.sv - first-word-fall-through FIFO controller around the buffer RAM
module buffer_fifo
    import buffer_fifo_pkg::*;
#(
    parameter int addrLen = 6,
    parameter int dataLen = 32,
    parameter int memSize = 1 << addrLen
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [dataLen-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [dataLen-1:0] out_data,
    output logic [addrLen:0]   count,
    output logic               full,
    output logic               empty
);

    localparam logic [addrLen:0] FULL_CNT = (addrLen + 1)'(memSize);

    logic [addrLen-1:0] wr_ptr;
    logic [addrLen-1:0] rd_ptr;
    logic [addrLen:0]   ram_cnt;
    logic               wrt;
    logic               rd_en;
    fifo_ev_t           ev;

    assign in_ready = (ram_cnt != FULL_CNT);
    assign ev       = decode_ev(in_valid, in_ready, out_valid, out_ready, ram_cnt != '0);

    // A flush cycle must not disturb RAM or the output register.
    assign wrt   = ev.accept & ~clear;
    assign rd_en = ev.issue & ~clear;

    buffer #(
        .addrLen (addrLen),
        .dataLen (dataLen),
        .memSize (memSize)
    ) u_buffer (
        .clk      (clk),
        .wrt      (wrt),
        .wrt_addr (wr_ptr),
        .data_in  (in_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_ptr),
        .data_out (out_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (ev.accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ev.issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({ev.accept, ev.issue})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
            if (ev.issue) begin
                out_valid <= 1'b1;
            end else if (ev.pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign count = ram_cnt + {{addrLen{1'b0}}, out_valid};
    assign full  = (ram_cnt == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: tb/tb_buffer_fifo.sv
// tb/tb_buffer_fifo.sv - self-checking bench for buffer_fifo against a queue model
module tb_buffer_fifo;

    localparam int AL  = 3;
    localparam int DL  = 32;
    localparam int MSZ = 1 << AL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DL-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DL-1:0] out_data;
    logic [AL:0]   count;
    logic          full;
    logic          empty;

    buffer_fifo #(.addrLen(AL), .dataLen(DL), .memSize(MSZ)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: every word held, oldest first; a stored word becomes visible one cycle later.
    logic [DL-1:0] q[$];
    logic          mv = 1'b0;
    logic [DL-1:0] popped[$];

    task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_in_ready();
        return (q.size() - int'(mv)) < MSZ;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, DL'(out_valid), DL'(mv));
        chk({tag, ".count"}, DL'(count), DL'(q.size()));
        chk({tag, ".in_ready"}, DL'(in_ready), DL'(m_in_ready()));
        chk({tag, ".full"}, DL'(full), DL'((q.size() - int'(mv)) == MSZ));
        chk({tag, ".empty"}, DL'(empty), DL'(q.size() == 0));
        if (mv) chk({tag, ".out_data"}, out_data, q[0]);
    endtask

    task automatic step(input logic iv, input logic [DL-1:0] d, input logic ordy,
                        input logic clr, input string tag, output logic acc);
        logic pop;
        logic nv;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        acc = iv & m_in_ready();
        pop = mv & ordy;
        @(posedge clk);
        #1;
        if (clr) begin
            q.delete();
            mv = 1'b0;
            acc = 1'b0;
        end else begin
            if (pop) popped.push_back(q.pop_front());
            nv = (q.size() > 0);
            if (acc) q.push_back(d);
            mv = nv;
        end
        clear = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        reset = 1'b0;
        q.delete(); mv = 1'b0; popped.delete();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic chk_order(input string name, input int n);
        int bad = 0;
        if (popped.size() != n) bad++;
        foreach (popped[i]) if (popped[i] !== DL'(i)) bad++;
        chk(name, DL'(bad), '0);
    endtask

    typedef struct {
        logic          iv;
        logic [DL-1:0] d;
        logic          ordy;
        logic          clr;
        logic          e_valid;
        logic [DL-1:0] e_data;
        int            e_count;
        logic          e_in_ready;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic acc;
        int   w;
        int   cyc;

        vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,          0, 1'b1};
        vecs[4]  = '{1'b1, 32'h11,        1'b1, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[5]  = '{1'b1, 32'h22,        1'b1, 1'b0, 1'b1, 32'h11,         2, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h22,         1, 1'b1};
        vecs[7]  = '{1'b1, 32'h33,        1'b0, 1'b1, 1'b0, 32'h0,          0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,          0, 1'b1};
        vecs[9]  = '{1'b1, 32'h77,        1'b0, 1'b0, 1'b0, 32'h0,          1, 1'b1};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h77,         1, 1'b1};

        // Reset then idle
        #2;
        @(posedge clk); #1;
        chk("rst.out_valid", DL'(out_valid), '0);
        chk("rst.count", DL'(count), '0);
        chk("rst.in_ready", DL'(in_ready), 1);
        chk("rst.empty", DL'(empty), 1);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0, "idle", acc);

        // Directed vectors: single word, back-to-back, clear, post-clear word
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].clr, $sformatf("vec%0d", i), acc);
            chk($sformatf("vec%0d.valid", i), DL'(out_valid), DL'(vecs[i].e_valid));
            chk($sformatf("vec%0d.count", i), DL'(count), DL'(vecs[i].e_count));
            chk($sformatf("vec%0d.in_ready", i), DL'(in_ready), DL'(vecs[i].e_in_ready));
            if (vecs[i].e_valid) chk($sformatf("vec%0d.data", i), out_data, vecs[i].e_data);
        end

        // Fill to capacity: 8 RAM entries plus the output register
        do_reset();
        w = 0;
        for (int i = 0; i < 12; i++) begin
            step(w < 10, DL'(w), 1'b0, 1'b0, "fill", acc);
            if (acc) w++;
        end
        chk("fill.accepted", DL'(w), 9);
        chk("fill.count9", DL'(count), 9);
        chk("fill.full", DL'(full), 1);
        chk("fill.in_ready", DL'(in_ready), 0);
        cyc = 0;
        while (popped.size() < 10 && cyc < 40) begin
            step(w < 10, DL'(w), 1'b1, 1'b0, "drain", acc);
            if (acc) w++;
            cyc++;
        end
        chk_order("fill.order", 10);

        // Streaming with wrap-around, no bubbles
        do_reset();
        w = 0; cyc = 0;
        while (popped.size() < 100 && cyc < 400) begin
            step(w < 100, DL'(w), 1'b1, 1'b0, "stream", acc);
            if (acc) w++;
            cyc++;
        end
        chk("stream.cycles", DL'(cyc), 102);
        chk_order("stream.order", 100);

        // Random valid/ready
        do_reset();
        w = 0; cyc = 0;
        while (popped.size() < 2000 && cyc < 20000) begin
            step((w < 2000) && ($urandom_range(1) == 1), $urandom, $urandom_range(1) == 1,
                 1'b0, "rand", acc);
            if (acc) w++;
            cyc++;
        end
        chk("rand.done", DL'(popped.size()), 2000);

        // Flush with 5 words held
        do_reset();
        for (int i = 0; i < 6; i++) step(i < 5, DL'(i + 100), 1'b0, 1'b0, "pre_clr", acc);
        chk("pre_clr.count", DL'(count), 5);
        step(1'b1, 32'hDEAD, 1'b0, 1'b1, "clr", acc);
        chk("clr.count", DL'(count), 0);
        chk("clr.valid", DL'(out_valid), 0);
        step(1'b1, 32'h77, 1'b0, 1'b0, "clr_w", acc);
        step(1'b0, '0, 1'b0, 1'b0, "clr_w", acc);
        chk("clr.next_valid", DL'(out_valid), 1);
        chk("clr.next_data", out_data, 32'h77);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 4; i++) step(1'b1, DL'(i + 200), 1'b0, 1'b0, "pre_rst", acc);
        chk("pre_rst.count", DL'(count), 5);
        #3;
        reset = 1'b0;
        #1;
        chk("arst.valid", DL'(out_valid), 0);
        chk("arst.count", DL'(count), 0);
        chk("arst.in_ready", DL'(in_ready), 1);
        chk("arst.empty", DL'(empty), 1);
        q.delete(); mv = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b1, 32'h77, 1'b0, 1'b0, "arst_w", acc);
        step(1'b0, '0, 1'b0, 1'b0, "arst_w", acc);
        chk("arst.next_valid", DL'(out_valid), 1);
        chk("arst.next_data", out_data, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
